// File: rtl/siso_frame_ctrl.sv
// Two-requester round-robin frame controller for an external DEPTH-stage SISO chain:
// serialises a word MSB-first onto sdin and recaptures it from sdout. Optional loopback check: SISO_CTRL_CHECK_EN.
module siso_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdin,
  input  logic             sdout,
  output logic             busy,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_src,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(WIDTH + DEPTH);
  localparam logic [CW-1:0] CNT_LASTB = CW'(DEPTH + 1);
  localparam logic [CW-1:0] CNT_CAP   = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_DONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] txsr_q, txsr_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sdin_q, sdin_d;
  logic             last_q, last_d;
  logic             rx_src_q, rx_src_d;
  logic             rxo_src_q, rxo_src_d;
  logic             rx_valid_q, rx_valid_d;

  logic             gnt0, gnt1, accept, frame_done;
  logic [WIDTH-1:0] word, cap_word;

  // last_q names the requester served most recently; the other one wins a tie.
  assign gnt0       = req0_valid & (~req1_valid | last_q);
  assign gnt1       = req1_valid & (~req0_valid | ~last_q);
  assign accept     = (state_q == IDLE) & (gnt0 | gnt1);
  assign frame_done = (state_q != IDLE) & (cnt_q == CNT_DONE);
  assign word       = gnt1 ? req1_data : req0_data;
  assign cap_word   = (cap_q << 1) | WIDTH'(sdout);

  assign req0_ready = (state_q == IDLE) & gnt0;
  assign req1_ready = (state_q == IDLE) & gnt1;
  assign sdin       = sdin_q;
  assign busy       = (state_q != IDLE);
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_src     = rxo_src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      txsr_q     <= '0;
      cap_q      <= '0;
      rx_data_q  <= '0;
      sdin_q     <= 1'b0;
      last_q     <= 1'b1;
      rx_src_q   <= 1'b0;
      rxo_src_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txsr_q     <= txsr_d;
      cap_q      <= cap_d;
      rx_data_q  <= rx_data_d;
      sdin_q     <= sdin_d;
      last_q     <= last_d;
      rx_src_q   <= rx_src_d;
      rxo_src_q  <= rxo_src_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // cnt counts edges remaining until the final capture; capture and shift windows overlap when WIDTH > DEPTH+1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txsr_d     = txsr_q;
    cap_d      = cap_q;
    rx_data_d  = rx_data_q;
    sdin_d     = 1'b0;
    last_d     = last_q;
    rx_src_d   = rx_src_q;
    rxo_src_d  = rxo_src_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          txsr_d   = word;
          sdin_d   = word[WIDTH-1];
          rx_src_d = gnt1;
          last_d   = gnt1;
          cnt_d    = CNT_LOAD;
          state_d  = SHIFT;
        end
      end
      SHIFT, DRAIN: begin
        cnt_d = cnt_q - CNT_DONE;
        if (state_q == SHIFT) begin
          if (cnt_q == CNT_LASTB) begin
            state_d = DRAIN;
          end else begin
            sdin_d = txsr_q[WIDTH-2];
            txsr_d = txsr_q << 1;
          end
        end
        if (cnt_q <= CNT_CAP) cap_d = cap_word;
        if (cnt_q == CNT_DONE) begin
          rx_valid_d = 1'b1;
          rx_data_d  = cap_word;
          rxo_src_d  = rx_src_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SISO_CTRL_CHECK_EN
  logic [WIDTH-1:0] tx_copy_q;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_copy_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) tx_copy_q <= word;
      err_q <= frame_done & (cap_word != tx_copy_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Bench for siso_frame_ctrl with a behavioural SISO chain and a timestamp-based frame model.
module tb_siso_frame_ctrl;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SISO_CTRL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic r0v, r1v, r0r, r1r;
  logic [W-1:0] r0d, r1d, rxd;
  logic sdin, sdout, busy, rxv, rxs, err;
  logic inv;
  logic [D-1:0] ch;

  logic b_v0, b_v1, b_r0, b_r1, b_sdin, b_sdout, b_busy, b_rxv, b_rxs, b_err;
  logic [1:0] b_d0, b_d1, b_rxd;
  logic [3:0] b_ch;

  int n = 0;
  int n_assert = 0;
  int n_fail = 0;

  // model state: one frame in flight, identified by its accept edge number
  bit          m_act, m_last, m_rxs, m_inj, hold, acc_flag;
  int          m_acc;
  bit          m_src;
  logic [31:0] m_word, m_rxw, m_rxd;

  always #5 clk = ~clk;
  always @(posedge clk) n <= n + 1;

  always @(posedge clk or posedge rst)
    if (rst) ch <= '0; else ch <= {ch[D-2:0], sdin};
  assign sdout = ch[D-1] ^ inv;

  always @(posedge clk or posedge rst)
    if (rst) b_ch <= '0; else b_ch <= {b_ch[2:0], b_sdin};
  assign b_sdout = b_ch[3];

  siso_frame_ctrl #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
    .sdin(sdin), .sdout(sdout), .busy(busy),
    .rx_valid(rxv), .rx_data(rxd), .rx_src(rxs), .err(err)
  );

  siso_frame_ctrl #(.WIDTH(2), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .sdin(b_sdin), .sdout(b_sdout), .busy(b_busy),
    .rx_valid(b_rxv), .rx_data(b_rxd), .rx_src(b_rxs), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready against the arbitration rule, then check all outputs after the edge.
  task automatic step();
    bit idle, g0, g1, rx_exp, err_exp;
    int k;
    idle = !m_act || (n - m_acc >= W + D);
    g0 = idle && r0v && (!r1v || m_last);
    g1 = idle && r1v && (!r0v || !m_last);
    #1;
    chk("ready0", 32'(r0r), 32'(g0));
    chk("ready1", 32'(r1r), 32'(g1));
    acc_flag = g0 || g1;
    if (acc_flag) begin
      m_act = 1'b1; m_acc = n + 1; m_src = g1; m_last = g1;
      m_word = g1 ? 32'(r1d) : 32'(r0d);
      m_rxw = m_word;
    end
    inv = m_inj && m_act && (n + 1 == m_acc + D + 3);
    @(posedge clk);
    @(negedge clk);
    inv = 1'b0;
    if (acc_flag && !hold) begin if (g0) r0v = 1'b0; else r1v = 1'b0; end
    if (acc_flag && hold) begin if (g0) r0d = W'($urandom); else r1d = W'($urandom); end
    k = n - m_acc;
    chk("sdin", 32'(sdin), (m_act && k < W) ? 32'(m_word[W-1-k]) : 32'd0);
    chk("busy", 32'(busy), 32'(m_act && k < W + D));
    rx_exp = m_act && (k == W + D);
    err_exp = 1'b0;
    if (rx_exp) begin
      m_rxd = m_rxw; m_rxs = m_src;
      err_exp = CHECK && (m_rxw != m_word);
    end
    chk("rx_valid", 32'(rxv), 32'(rx_exp));
    chk("rx_data", 32'(rxd), m_rxd);
    chk("rx_src", 32'(rxs), 32'(m_rxs));
    chk("err", 32'(err), 32'(err_exp));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic wait_accept(input string tag);
    int t = 0;
    do begin step(); t++; end while (!acc_flag && t < 40);
    if (!acc_flag) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; r0v = 1'b0; r1v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_act = 1'b0; m_last = 1'b1; m_rxd = '0; m_rxs = 1'b0;
    chk("rst_sdin", 32'(sdin), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rxv), 32'd0);
    chk("rst_rx_data", 32'(rxd), 32'd0);
    chk("rst_rx_src", 32'(rxs), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int c2;
    rst = 1'b1; inv = 1'b0;
    r0v = 1'b0; r1v = 1'b0; r0d = '0; r1d = '0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0;
    m_act = 1'b0; m_last = 1'b1; m_rxd = '0; m_rxs = 1'b0; m_inj = 1'b0; hold = 1'b0;
    m_acc = -1000; m_word = '0; m_rxw = '0; m_src = 1'b0; acc_flag = 1'b0;
    repeat (2) @(negedge clk);
    pulse_rst();

    // single frame from req0
    r0v = 1'b1; r0d = 8'hA5;
    run(16);

    // tie from reset: req0 first, then req1 13 cycles later
    pulse_rst();
    r0v = 1'b1; r0d = 8'h3C; r1v = 1'b1; r1d = 8'hC3;
    run(30);

    // both held valid for back-to-back frames
    hold = 1'b1; r0v = 1'b1; r1v = 1'b1; r0d = W'($urandom); r1d = W'($urandom);
    run(4 * (W + D + 1));
    hold = 1'b0; r0v = 1'b0; r1v = 1'b0;
    run(W + D + 2);

    // reset asserted across E5 of a frame
    r0v = 1'b1; r0d = 8'h5A;
    wait_accept("abort");
    run(4);
    pulse_rst();
    r0v = 1'b1; r0d = 8'hFF;
    run(W + D + 4);

    // loopback corruption on the 3rd capture edge of a 0x00 frame
    r1v = 1'b1; r1d = 8'h00;
    wait_accept("inject");
    m_inj = 1'b1; m_rxw = m_word ^ 32'h20;
    run(W + D + 2);
    m_inj = 1'b0;

    // randomized traffic, including valids withdrawn while busy
    for (int i = 0; i < 150; i++) begin
      if (!r0v) begin r0v = 1'($urandom); r0d = W'($urandom); end
      else if (busy && ($urandom % 4 == 0)) r0v = 1'b0;
      if (!r1v) begin r1v = 1'($urandom); r1d = W'($urandom); end
      else if (busy && ($urandom % 4 == 0)) r1v = 1'b0;
      step();
    end
    r0v = 1'b0; r1v = 1'b0;
    run(W + D + 2);

    // WIDTH=2 instance: 0b10 returns after 6 cycles
    b_v0 = 1'b1; b_d0 = 2'b10;
    #1;
    chk("w2_ready", 32'(b_r0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_v0 = 1'b0;
    chk("w2_sdin_b1", 32'(b_sdin), 32'd1);
    c2 = 0;
    do begin
      @(posedge clk); c2++;
      @(negedge clk);
      if (c2 == 1) chk("w2_sdin_b0", 32'(b_sdin), 32'd0);
    end while (!b_rxv && c2 < 20);
    chk("w2_latency", 32'(c2), 32'd6);
    chk("w2_rx_data", 32'(b_rxd), 32'd2);
    chk("w2_rx_src", 32'(b_rxs), 32'd0);
    chk("w2_err", 32'(b_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
